// File: rtl/matrix_3x3_gen.sv
// 3x3 pixel window generator: two column-indexed line RAMs feed a registered window with aligned syncs.
// Optional MATRIX_BORDER_ZERO_EN: full-size output frame with out-of-image taps forced to zero.
module matrix_3x3_gen #(
   parameter int unsigned IMG_WIDTH  = 640,
   parameter int unsigned IMG_HEIGHT = 480,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  pix_vsync,
   input  logic                  pix_href,
   input  logic                  pix_de,
   input  logic [DATA_WIDTH-1:0] pix_data,
   output logic                  matrix_vsync,
   output logic                  matrix_href,
   output logic                  matrix_de,
   output logic                  matrix_valid,
   output logic [DATA_WIDTH-1:0] matrix_p11,
   output logic [DATA_WIDTH-1:0] matrix_p12,
   output logic [DATA_WIDTH-1:0] matrix_p13,
   output logic [DATA_WIDTH-1:0] matrix_p21,
   output logic [DATA_WIDTH-1:0] matrix_p22,
   output logic [DATA_WIDTH-1:0] matrix_p23,
   output logic [DATA_WIDTH-1:0] matrix_p31,
   output logic [DATA_WIDTH-1:0] matrix_p32,
   output logic [DATA_WIDTH-1:0] matrix_p33
);

   localparam int unsigned CW = (IMG_WIDTH  > 4) ? $clog2(IMG_WIDTH)  : 2;
   localparam int unsigned RW = (IMG_HEIGHT > 4) ? $clog2(IMG_HEIGHT) : 2;

   typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

   state_t                state;
   logic                  vsync_q;
   logic [CW-1:0]         col_cnt;
   logic [RW-1:0]         row_cnt;
   logic [DATA_WIDTH-1:0] lb1 [IMG_WIDTH];
   logic [DATA_WIDTH-1:0] lb2 [IMG_WIDTH];
   logic [DATA_WIDTH-1:0] tap1;
   logic [DATA_WIDTH-1:0] tap2;
   logic                  vsync_rise;
   logic                  qual;
   logic                  col_last;
   logic                  row_last;
   logic                  win_ok;

   assign vsync_rise = pix_vsync & ~vsync_q;
   assign qual       = pix_de & (state == ACTIVE) & ~vsync_rise;
   assign col_last   = (col_cnt == CW'(IMG_WIDTH - 1));
   assign row_last   = (row_cnt == RW'(IMG_HEIGHT - 1));
   assign tap1       = lb1[col_cnt];
   assign tap2       = lb2[col_cnt];

`ifdef MATRIX_BORDER_ZERO_EN
   assign win_ok = 1'b1;
`else
   assign win_ok = (row_cnt >= RW'(2)) && (col_cnt >= CW'(2));
`endif

   // Frame FSM, position counters and sync alignment
   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= IDLE;
         vsync_q      <= 1'b0;
         col_cnt      <= '0;
         row_cnt      <= '0;
         matrix_vsync <= 1'b0;
         matrix_href  <= 1'b0;
         matrix_de    <= 1'b0;
         matrix_valid <= 1'b0;
      end else begin
         vsync_q      <= pix_vsync;
         matrix_vsync <= pix_vsync;
         matrix_href  <= pix_href;
         matrix_de    <= qual;
         matrix_valid <= qual & win_ok;
         if (vsync_rise) begin
            state   <= ACTIVE;
            col_cnt <= '0;
            row_cnt <= '0;
         end else if (qual) begin
            if (col_last) begin
               col_cnt <= '0;
               if (row_last) state <= DONE;
               else          row_cnt <= row_cnt + RW'(1);
            end else begin
               col_cnt <= col_cnt + CW'(1);
            end
         end
      end
   end

   // Line RAMs: read-before-write cascade, contents never reset
   always_ff @(posedge clock) begin
      if (qual && !reset) begin
         lb1[col_cnt] <= pix_data;
         lb2[col_cnt] <= tap1;
      end
   end

`ifdef MATRIX_BORDER_ZERO_EN
   logic [DATA_WIDTH-1:0] w12, w13, w22, w23, w32, w33;
   logic                  zr1, zr2, zc1, zc2;

   assign zr1 = (row_cnt <= RW'(1));
   assign zr2 = (row_cnt == RW'(0));
   assign zc1 = (col_cnt <= CW'(1));
   assign zc2 = (col_cnt == CW'(0));

   // Unmasked shift window; outputs are a masked copy of its next value
   always_ff @(posedge clock) begin
      if (reset) begin
         {w12, w13, w22, w23, w32, w33} <= '0;
         {matrix_p11, matrix_p12, matrix_p13} <= '0;
         {matrix_p21, matrix_p22, matrix_p23} <= '0;
         {matrix_p31, matrix_p32, matrix_p33} <= '0;
      end else if (qual) begin
         w12 <= w13;  w13 <= tap2;
         w22 <= w23;  w23 <= tap1;
         w32 <= w33;  w33 <= pix_data;
         matrix_p11 <= (zr1 | zc1) ? '0 : w12;
         matrix_p12 <= (zr1 | zc2) ? '0 : w13;
         matrix_p13 <= zr1         ? '0 : tap2;
         matrix_p21 <= (zr2 | zc1) ? '0 : w22;
         matrix_p22 <= (zr2 | zc2) ? '0 : w23;
         matrix_p23 <= zr2         ? '0 : tap1;
         matrix_p31 <= zc1         ? '0 : w32;
         matrix_p32 <= zc2         ? '0 : w33;
         matrix_p33 <= pix_data;
      end
   end
`else
   // Output registers are the window itself
   always_ff @(posedge clock) begin
      if (reset) begin
         {matrix_p11, matrix_p12, matrix_p13} <= '0;
         {matrix_p21, matrix_p22, matrix_p23} <= '0;
         {matrix_p31, matrix_p32, matrix_p33} <= '0;
      end else if (qual) begin
         matrix_p11 <= matrix_p12;  matrix_p12 <= matrix_p13;  matrix_p13 <= tap2;
         matrix_p21 <= matrix_p22;  matrix_p22 <= matrix_p23;  matrix_p23 <= tap1;
         matrix_p31 <= matrix_p32;  matrix_p32 <= matrix_p33;  matrix_p33 <= pix_data;
      end
   end
`endif

endmodule

// File: tb/tb_matrix_3x3_gen.sv
// Scoreboard bench for matrix_3x3_gen on an 8x6 ramp frame (pixel = row*16 + col).
module tb_matrix_3x3_gen;

   localparam int W = 8;
   localparam int H = 6;
`ifdef MATRIX_BORDER_ZERO_EN
   localparam bit BZ = 1'b1;
`else
   localparam bit BZ = 1'b0;
`endif
   localparam int EXP_VALID = BZ ? W * H : (W - 2) * (H - 2);
   localparam int FIRST_COL = BZ ? 0 : 2;

   logic       clock, reset, pix_vsync, pix_href, pix_de;
   logic [7:0] pix_data;
   logic       matrix_vsync, matrix_href, matrix_de, matrix_valid;
   logic [7:0] matrix_p11, matrix_p12, matrix_p13;
   logic [7:0] matrix_p21, matrix_p22, matrix_p23;
   logic [7:0] matrix_p31, matrix_p32, matrix_p33;

   matrix_3x3_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(8)) dut (
      .clock(clock), .reset(reset),
      .pix_vsync(pix_vsync), .pix_href(pix_href), .pix_de(pix_de), .pix_data(pix_data),
      .matrix_vsync(matrix_vsync), .matrix_href(matrix_href),
      .matrix_de(matrix_de), .matrix_valid(matrix_valid),
      .matrix_p11(matrix_p11), .matrix_p12(matrix_p12), .matrix_p13(matrix_p13),
      .matrix_p21(matrix_p21), .matrix_p22(matrix_p22), .matrix_p23(matrix_p23),
      .matrix_p31(matrix_p31), .matrix_p32(matrix_p32), .matrix_p33(matrix_p33)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct packed {
      logic [71:0] win;
      logic [7:0]  col;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   valid_cnt = 0;
   int   de_cnt = 0;
   int   last_valid_cyc = 0;
   bit   gap_mode = 1'b0;

   function automatic logic [7:0] ramp(int r, int c);
      if (r < 0 || c < 0) return 8'h00;
      return 8'(r * 16 + c);
   endfunction

   // Window for input pixel (r,c): rows r-2..r, cols c-2..c, packed p11 first
   function automatic logic [71:0] exp_win(int r, int c);
      logic [71:0] v;
      v = '0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            v = {v[63:0], ramp(r - 2 + i, c - 2 + j)};
      return v;
   endfunction

   function automatic void check(string name, logic [71:0] act, logic [71:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   // Monitor: pops the scoreboard on every valid window
   always @(negedge clock) begin
      exp_t e;
      cyc++;
      if (!reset) begin
         if (matrix_de) de_cnt++;
         if (matrix_valid) begin
            valid_cnt++;
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_valid: got valid at cycle %0d expected none", cyc);
            end else begin
               e = sb.pop_front();
               check("window", {matrix_p11, matrix_p12, matrix_p13, matrix_p21, matrix_p22,
                                matrix_p23, matrix_p31, matrix_p32, matrix_p33}, e.win);
               if (gap_mode && int'(e.col) != FIRST_COL)
                  check("gap_spacing", 72'(cyc - last_valid_cyc), 72'(3));
               last_valid_cyc = cyc;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send_pix(int r, int c, int gap, bit push);
      pix_de   = 1'b1;
      pix_href = 1'b1;
      pix_data = ramp(r, c);
      if (push && (BZ || (r >= 2 && c >= 2)))
         sb.push_back({exp_win(r, c), 8'(c)});
      tick();
      pix_de = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic frame_start();
      pix_vsync = 1'b1;
      tick();
      pix_vsync = 1'b0;
      tick();
   endtask

   task automatic send_frame(int gap);
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) send_pix(r, c, gap, 1'b1);
         pix_href = 1'b0;
         tick();
      end
   endtask

   task automatic frame_counts(string name, int exp_valid, int exp_de);
      repeat (3) tick();
      check({name, "_valid_count"}, 72'(valid_cnt), 72'(exp_valid));
      check({name, "_de_count"}, 72'(de_cnt), 72'(exp_de));
      check({name, "_queue_left"}, 72'(sb.size()), 72'(0));
      sb.delete();
      valid_cnt = 0;
      de_cnt = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; pix_vsync = 1'b0; pix_href = 1'b0; pix_de = 1'b0; pix_data = '0;
      repeat (3) tick();
      check("reset_outputs", {matrix_vsync, matrix_href, matrix_de, matrix_valid,
                              matrix_p11, matrix_p12, matrix_p13, matrix_p21, matrix_p22,
                              matrix_p23, matrix_p31, matrix_p32}, '0);
      check("reset_p33", 72'(matrix_p33), 72'(0));
      reset = 1'b0;
      tick();

      // de without a frame start is ignored
      for (int i = 0; i < 5; i++) send_pix(0, i, 0, 1'b0);
      repeat (2) tick();
      check("idle_de", 72'(de_cnt), 72'(0));
      check("idle_valid", 72'(valid_cnt), 72'(0));

      frame_start();
      send_frame(0);
      frame_counts("cont", EXP_VALID, W * H);

      // Extra pixels in DONE produce nothing
      for (int i = 0; i < 3; i++) send_pix(0, i, 1, 1'b0);
      repeat (2) tick();
      check("done_de", 72'(de_cnt), 72'(0));

      frame_start();
      send_frame(0);
      frame_counts("second", EXP_VALID, W * H);

      gap_mode = 1'b1;
      frame_start();
      send_frame(2);
      frame_counts("gapped", EXP_VALID, W * H);
      gap_mode = 1'b0;

      // Abort at row 3 col 5; the pixel in the vsync cycle must be dropped
      frame_start();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < ((r == 3) ? 5 : W); c++) send_pix(r, c, 0, 1'b1);
      pix_vsync = 1'b1; pix_de = 1'b1; pix_data = 8'hFF;
      tick();
      pix_vsync = 1'b0; pix_de = 1'b0;
      frame_counts("aborted", BZ ? 29 : 9, 29);
      send_frame(0);
      frame_counts("after_abort", EXP_VALID, W * H);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
